nn_load_sequencer: RTL and testbench
====================================

Name: nn_load_sequencer

Overview:
Frame-level controller that sequences the SDRAM loader (get_image/get_coeffs/layer/busy) and the layer compute engine for one inference pass. On start it loads the 8x8 image once. For each layer 0..LAYER_COUNT-1 it then loads that layer's coefficients and runs that layer's compute. It guards every loader and compute handshake with a watchdog and reports completion or error to the top level.

Parameters:
NUMLAYERS, 2, width of layer/layer_idx fields
LAYER_COUNT, 3, number of layers sequenced per frame (1..2**NUMLAYERS)
TIMEOUT, 4096, max cycles allowed in any wait state before error
TOBITS, 13, watchdog counter width (must hold TIMEOUT)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin one frame; sampled only in IDLE, DONE or ERROR
abort  in  1  return to IDLE from any state next cycle
ld_busy  in  1  loader busy (high while a load is in progress)
get_image  out  1  one-cycle pulse: request image load
get_coeffs  out  1  one-cycle pulse: request coefficient load
layer  out  NUMLAYERS  layer select to loader; valid with get_coeffs and held until the next request
compute_start  out  1  one-cycle pulse: run compute for layer_idx
compute_done  in  1  one-cycle pulse from compute engine
layer_idx  out  NUMLAYERS  layer currently loading or computing
busy  out  1  high in every state except IDLE, DONE, ERROR
frame_done  out  1  one-cycle pulse on entry to DONE
error  out  1  sticky; high in ERROR
err_code  out  2  01 loader ack timeout, 10 loader finish timeout, 11 compute timeout, 00 none

Behaviour:
- Reset: state IDLE; all outputs 0; layer=0; layer_idx=0; watchdog=0.
- States:
  - IDLE, IMG_REQ, IMG_ACK, IMG_WAIT, COEF_REQ, COEF_ACK, COEF_WAIT, COMP_REQ, COMP_WAIT, DONE, ERROR.
- Transitions:
  - IDLE/DONE/ERROR --start--> IMG_REQ. Leaving ERROR clears error and err_code. layer_idx=0.
  - IMG_REQ: get_image=1 for exactly this cycle -> IMG_ACK.
  - IMG_ACK: wait ld_busy=1 -> IMG_WAIT. The loader raises busy one cycle after the request, so the minimum stay is 1 cycle.
  - IMG_WAIT: wait ld_busy=0 -> COEF_REQ.
  - COEF_REQ: get_coeffs=1 and layer=layer_idx for this cycle -> COEF_ACK.
  - COEF_ACK/COEF_WAIT: same rules as IMG_ACK/IMG_WAIT; COEF_WAIT exits -> COMP_REQ.
  - COMP_REQ: compute_start=1 for this cycle -> COMP_WAIT.
  - COMP_WAIT on compute_done:
    - if layer_idx==LAYER_COUNT-1: -> DONE, frame_done=1 that cycle.
    - else: layer_idx+1 -> COEF_REQ.
  - DONE: busy=0; layer_idx holds its last value; idle until start.
- Request rule: never issue get_image or get_coeffs while ld_busy=1. If ld_busy is high on entry to IMG_REQ or COEF_REQ, stall there, with no pulse, until it drops. The stall counts against the watchdog with err_code 01.
- Watchdog:
  - Clears on every state change; increments each cycle in IMG_REQ/ACK/WAIT, COEF_REQ/ACK/WAIT, COMP_WAIT.
  - Reaching TIMEOUT-1 -> ERROR next cycle and sets err_code:
    - 01 from *_REQ or *_ACK;
    - 10 from *_WAIT loader states;
    - 11 from COMP_WAIT.
  - error=1 while in ERROR.
- abort:
  - Forces IDLE next cycle from any state and clears error and err_code.
  - Suppresses any request pulse that would occur that cycle.
  - abort has priority over start and compute_done.
- compute_done outside COMP_WAIT is ignored. A late compute_done after a timeout is ignored.
- start while busy=1 is ignored (no restart).
- Simultaneous events in COMP_WAIT: compute_done wins over watchdog expiry in the same cycle.
- Reset mid-operation: immediate return to reset values; no pulse outputs glitch high.
- All outputs are registered or decoded from the registered state only; no combinational path from any input to any output.

Test Plan:
- Nominal frame, LAYER_COUNT=3: loader model busy 2 cycles after a request for 64 cycles, compute_done 10 cycles after start -> order get_image, then (get_coeffs with layer=0, compute_start) x3 with layer 0,1,2; frame_done exactly once; busy falls the same cycle DONE is entered.
- Loader never asserts busy after get_image, TIMEOUT=16 -> error=1 and err_code=01 exactly 16 cycles after the IMG_ACK entry; no further requests; start then clears error and reissues get_image.
- compute_done never arrives at layer 1 -> err_code=11, layer_idx=1, get_coeffs for layer 2 is never issued.
- ld_busy held high on entry to COEF_REQ for 5 cycles -> get_coeffs is withheld and pulses on the first cycle after ld_busy falls.
- abort asserted in COEF_WAIT together with compute_done -> IDLE next cycle, busy=0, no compute_start, error=0.
- reset_n low in COMP_WAIT, then a start pulse 3 cycles after release -> all outputs 0 during reset; a fresh frame starts with get_image and layer_idx=0.

Source files
------------

// File: rtl/nn_load_sequencer_if.sv
// Handshake bundle between the inference sequencer, the SDRAM loader,
// the compute engine and the top-level frame controls.
interface nn_load_sequencer_if #(
  parameter int NUMLAYERS = 2
) ();
  logic                 start;
  logic                 abort;
  logic                 ld_busy;
  logic                 get_image;
  logic                 get_coeffs;
  logic [NUMLAYERS-1:0] layer;
  logic                 compute_start;
  logic                 compute_done;
  logic [NUMLAYERS-1:0] layer_idx;
  logic                 busy;
  logic                 frame_done;
  logic                 error;
  logic [1:0]           err_code;

  modport master (
    input  start, abort, ld_busy, compute_done,
    output get_image, get_coeffs, layer, compute_start, layer_idx,
           busy, frame_done, error, err_code
  );

  modport slave (
    output start, abort, ld_busy, compute_done,
    input  get_image, get_coeffs, layer, compute_start, layer_idx,
           busy, frame_done, error, err_code
  );
endinterface

// File: rtl/nn_load_sequencer.sv
// Frame controller: loads the image once, then per layer loads coefficients and
// runs compute, with a watchdog on every wait state.
module nn_load_sequencer #(
  parameter int NUMLAYERS   = 2,
  parameter int LAYER_COUNT = 3,
  parameter int TIMEOUT     = 4096,
  parameter int TOBITS      = 13
) (
  input  logic                clk,
  input  logic                reset_n,
  nn_load_sequencer_if.master bus
);

  localparam logic [TOBITS-1:0]    WD_LIMIT   = TOBITS'(TIMEOUT - 1);
  localparam logic [NUMLAYERS-1:0] LAST_LAYER = NUMLAYERS'(LAYER_COUNT - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_IMG_REQ   = 4'd1,
    S_IMG_ACK   = 4'd2,
    S_IMG_WAIT  = 4'd3,
    S_COEF_REQ  = 4'd4,
    S_COEF_ACK  = 4'd5,
    S_COEF_WAIT = 4'd6,
    S_COMP_REQ  = 4'd7,
    S_COMP_WAIT = 4'd8,
    S_DONE      = 4'd9,
    S_ERROR     = 4'd10
  } state_t;

  state_t               state_r, state_s;
  logic [TOBITS-1:0]    wd_r, wd_s;
  logic [NUMLAYERS-1:0] layer_idx_r, layer_idx_s;
  logic [NUMLAYERS-1:0] layer_r;
  logic [1:0]           err_code_r, err_code_s;
  logic                 get_image_r, get_coeffs_r, compute_start_r, frame_done_r;
  logic                 wd_expired_s, wd_run_s;

  // Next-state, layer index and error code selection.
  always_comb begin
    state_s      = state_r;
    layer_idx_s  = layer_idx_r;
    err_code_s   = err_code_r;
    wd_expired_s = (wd_r == WD_LIMIT);
    if (bus.abort) begin
      state_s    = S_IDLE;
      err_code_s = 2'b00;
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            state_s     = S_IMG_REQ;
            layer_idx_s = {NUMLAYERS{1'b0}};
            err_code_s  = 2'b00;
          end else begin
            state_s = state_r;
          end
        end
        // Request states leave only once the registered pulse has actually gone out.
        S_IMG_REQ, S_COEF_REQ: begin
          if (get_image_r || get_coeffs_r) begin
            state_s = (state_r == S_IMG_REQ) ? S_IMG_ACK : S_COEF_ACK;
          end else if (wd_expired_s) begin
            state_s    = S_ERROR;
            err_code_s = 2'b01;
          end else begin
            state_s = state_r;
          end
        end
        S_IMG_ACK, S_COEF_ACK: begin
          if (bus.ld_busy) begin
            state_s = (state_r == S_IMG_ACK) ? S_IMG_WAIT : S_COEF_WAIT;
          end else if (wd_expired_s) begin
            state_s    = S_ERROR;
            err_code_s = 2'b01;
          end else begin
            state_s = state_r;
          end
        end
        S_IMG_WAIT, S_COEF_WAIT: begin
          if (!bus.ld_busy) begin
            state_s = (state_r == S_IMG_WAIT) ? S_COEF_REQ : S_COMP_REQ;
          end else if (wd_expired_s) begin
            state_s    = S_ERROR;
            err_code_s = 2'b10;
          end else begin
            state_s = state_r;
          end
        end
        S_COMP_REQ: begin
          state_s = S_COMP_WAIT;
        end
        S_COMP_WAIT: begin
          if (bus.compute_done) begin
            if (layer_idx_r == LAST_LAYER) begin
              state_s = S_DONE;
            end else begin
              state_s     = S_COEF_REQ;
              layer_idx_s = layer_idx_r + {{(NUMLAYERS-1){1'b0}}, 1'b1};
            end
          end else if (wd_expired_s) begin
            state_s    = S_ERROR;
            err_code_s = 2'b11;
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Watchdog: restarts on any state change, counts only in guarded states.
  always_comb begin
    case (state_r)
      S_IMG_REQ, S_IMG_ACK, S_IMG_WAIT,
      S_COEF_REQ, S_COEF_ACK, S_COEF_WAIT, S_COMP_WAIT: wd_run_s = 1'b1;
      default:                                           wd_run_s = 1'b0;
    endcase
    if (state_s != state_r) begin
      wd_s = {TOBITS{1'b0}};
    end else if (wd_run_s) begin
      wd_s = wd_r + {{(TOBITS-1){1'b0}}, 1'b1};
    end else begin
      wd_s = wd_r;
    end
  end

  // State, watchdog, layer index and error code registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      wd_r        <= {TOBITS{1'b0}};
      layer_idx_r <= {NUMLAYERS{1'b0}};
      err_code_r  <= 2'b00;
    end else begin
      state_r     <= state_s;
      wd_r        <= wd_s;
      layer_idx_r <= layer_idx_s;
      err_code_r  <= err_code_s;
    end
  end

  // Registered pulses; a request is withheld while the loader reported busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      get_image_r     <= 1'b0;
      get_coeffs_r    <= 1'b0;
      compute_start_r <= 1'b0;
      frame_done_r    <= 1'b0;
      layer_r         <= {NUMLAYERS{1'b0}};
    end else begin
      get_image_r     <= (state_s == S_IMG_REQ) && !bus.ld_busy;
      get_coeffs_r    <= (state_s == S_COEF_REQ) && !bus.ld_busy;
      compute_start_r <= (state_s == S_COMP_REQ);
      frame_done_r    <= (state_s == S_DONE) && (state_r != S_DONE);
      if ((state_s == S_COEF_REQ) && !bus.ld_busy) begin
        layer_r <= layer_idx_s;
      end else begin
        layer_r <= layer_r;
      end
    end
  end

  assign bus.get_image     = get_image_r;
  assign bus.get_coeffs    = get_coeffs_r;
  assign bus.compute_start = compute_start_r;
  assign bus.frame_done    = frame_done_r;
  assign bus.layer         = layer_r;
  assign bus.layer_idx     = layer_idx_r;
  assign bus.err_code      = err_code_r;
  assign bus.busy          = !((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERROR));
  assign bus.error         = (state_r == S_ERROR);

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Bench: short-timeout instance driven from a vector table, default instance
// driven by loader/compute models with an event scoreboard.
module tb_nn_load_sequencer;
  localparam int NL = 2;
  localparam logic [2:0] K_IMG = 3'd1, K_COEF = 3'd2, K_COMP = 3'd3, K_DONE = 3'd4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nn_load_sequencer_if #(.NUMLAYERS(NL)) bus0 ();
  nn_load_sequencer_if #(.NUMLAYERS(NL)) bus1 ();

  nn_load_sequencer #(.NUMLAYERS(NL), .LAYER_COUNT(3), .TIMEOUT(4096), .TOBITS(13)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  nn_load_sequencer #(.NUMLAYERS(NL), .LAYER_COUNT(3), .TIMEOUT(16), .TOBITS(5)) dut_short (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  typedef struct packed { logic [2:0] kind; logic [NL-1:0] lyr; } ev_t;
  typedef struct { int n; logic st, ab, lb, cd; logic [11:0] exp; } vec_t;

  ev_t  sb0[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  logic mdl_busy, mdl_done, ld_force, cdone_man, prev_busy;
  int   ld_pend, ld_left, cmp_cnt;
  assign bus0.ld_busy      = mdl_busy | ld_force;
  assign bus0.compute_done = mdl_done | cdone_man;

  function automatic logic [11:0] pack0();
    return {bus0.get_image, bus0.get_coeffs, bus0.compute_start, bus0.frame_done, bus0.busy,
            bus0.error, bus0.err_code, bus0.layer_idx, bus0.layer};
  endfunction
  function automatic logic [11:0] pack1();
    return {bus1.get_image, bus1.get_coeffs, bus1.compute_start, bus1.frame_done, bus1.busy,
            bus1.error, bus1.err_code, bus1.layer_idx, bus1.layer};
  endfunction

  task automatic check12(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", nm, act, exp);
    end
  endtask

  task automatic add_vec(input int n, input bit st, ab, lb, cd, gi, gc, cs, bs, er,
                         input logic [1:0] ec, li, ly);
    vec_t v;
    v.n = n; v.st = st; v.ab = ab; v.lb = lb; v.cd = cd;
    v.exp = {gi, gc, cs, 1'b0, bs, er, ec, li, ly};
    tbl.push_back(v);
  endtask

  task automatic sb_check(input logic [2:0] kind, input logic [NL-1:0] lyr);
    ev_t e;
    checks++;
    if (sb0.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind %0d layer %0d, required no event", kind, lyr);
    end else begin
      e = sb0.pop_front();
      if (e.kind !== kind || e.lyr !== lyr) begin
        errors++;
        $display("FAIL sb_order: got kind %0d layer %0d, required kind %0d layer %0d",
                 kind, lyr, e.kind, e.lyr);
      end
    end
  endtask

  task automatic push_frame();
    sb0.push_back('{K_IMG, 2'd0});
    for (int l = 0; l < 3; l++) begin
      sb0.push_back('{K_COEF, NL'(l)});
      sb0.push_back('{K_COMP, NL'(l)});
    end
    sb0.push_back('{K_DONE, 2'd2});
  endtask

  task automatic pulse_start();
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  task automatic drain(input int budget, input string nm);
    for (int c = 0; c < budget && sb0.size() != 0; c++) @(negedge clk);
    checks++;
    if (sb0.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d events pending, required 0", nm, sb0.size());
      sb0.delete();
    end
  endtask

  task automatic wait_sig(input logic [2:0] kind, input int budget, input string nm);
    bit hit = 1'b0;
    for (int c = 0; c < budget && !hit; c++) begin
      @(negedge clk);
      hit = (kind == K_COMP) ? bus0.compute_start : bus0.get_coeffs;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: got no pulse within %0d cycles, required one", nm, budget);
    end
  endtask

  // Loader (busy 2 cycles after a request, for 64 cycles) and compute (done 10 cycles after start).
  always @(negedge clk) begin
    if (!reset_n) begin
      mdl_busy = 1'b0; mdl_done = 1'b0; ld_pend = 0; ld_left = 0; cmp_cnt = 0;
    end else begin
      if (ld_left != 0) begin
        ld_left--;
        if (ld_left == 0) mdl_busy = 1'b0;
      end
      if (ld_pend != 0) begin
        ld_pend--;
        if (ld_pend == 0) begin mdl_busy = 1'b1; ld_left = 64; end
      end
      if (bus0.get_image || bus0.get_coeffs) ld_pend = 2;
      mdl_done = 1'b0;
      if (cmp_cnt != 0) begin
        cmp_cnt--;
        if (cmp_cnt == 0) mdl_done = 1'b1;
      end
      if (bus0.compute_start) cmp_cnt = 10;
    end
  end

  // Scoreboard monitor for the model-driven instance.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus0.get_image)     sb_check(K_IMG, bus0.layer_idx);
      if (bus0.get_coeffs)    sb_check(K_COEF, bus0.layer);
      if (bus0.compute_start) sb_check(K_COMP, bus0.layer_idx);
      if (bus0.frame_done) begin
        sb_check(K_DONE, bus0.layer_idx);
        checks++;
        if (bus0.busy || !prev_busy) begin
          errors++;
          $display("FAIL done_busy: got busy %b prev %b, required 0 after 1", bus0.busy, prev_busy);
        end
      end
    end
    prev_busy = bus0.busy;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus0.start = 1'b0; bus0.abort = 1'b0; ld_force = 1'b0; cdone_man = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.ld_busy = 1'b0; bus1.compute_done = 1'b0;

    //       n   st ab lb cd  gi gc cs bs er  ec     li     ly
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  1, 0, 0, 0,  1, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(15, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 0, 1, 2'b01, 2'd0, 2'd0);
    add_vec(20, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2'b01, 2'd0, 2'd0);
    add_vec(1,  1, 0, 0, 0,  1, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 1, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  1, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(15, 0, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 1, 0,  0, 0, 0, 0, 1, 2'b01, 2'd0, 2'd0);
    add_vec(1,  1, 0, 0, 0,  1, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(15, 0, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 1, 0,  0, 0, 0, 0, 1, 2'b10, 2'd0, 2'd0);
    add_vec(1,  1, 0, 0, 0,  1, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 1, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  1, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(15, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd0, 2'd0);
    add_vec(1,  0, 0, 0, 1,  0, 1, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    add_vec(1,  0, 0, 1, 0,  0, 0, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    add_vec(1,  0, 0, 0, 0,  0, 0, 1, 1, 0, 2'b00, 2'd1, 2'd1);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    add_vec(15, 0, 0, 0, 0,  0, 0, 0, 1, 0, 2'b00, 2'd1, 2'd1);
    add_vec(1,  0, 0, 0, 0,  0, 0, 0, 0, 1, 2'b11, 2'd1, 2'd1);
    add_vec(3,  0, 0, 0, 1,  0, 0, 0, 0, 1, 2'b11, 2'd1, 2'd1);
    add_vec(1,  0, 1, 0, 0,  0, 0, 0, 0, 0, 2'b00, 2'd1, 2'd1);

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check12("reset_state", pack0(), 12'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      bus1.start = tbl[i].st; bus1.abort = tbl[i].ab;
      bus1.ld_busy = tbl[i].lb; bus1.compute_done = tbl[i].cd;
      repeat (tbl[i].n) @(negedge clk);
      check12($sformatf("vec%0d", i), pack1(), tbl[i].exp);
    end
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.ld_busy = 1'b0; bus1.compute_done = 1'b0;

    // Nominal frame.
    push_frame();
    pulse_start();
    drain(2000, "nominal_drain");
    check12("nominal_done", pack0(), {4'b0000, 1'b0, 1'b0, 2'b00, 2'd2, 2'd2});
    repeat (20) @(negedge clk);

    // Loader busy on entry to COEF_REQ for layer 1.
    push_frame();
    pulse_start();
    wait_sig(K_COMP, 1000, "stall_comp0");
    ld_force = 1'b1;
    repeat (10) @(negedge clk);
    begin
      int early = 0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus0.get_coeffs) early++;
      end
      checks++;
      if (early != 0) begin
        errors++;
        $display("FAIL stall_withheld: got %0d get_coeffs pulses, required 0", early);
      end
    end
    ld_force = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.get_coeffs !== 1'b1 || bus0.layer !== 2'd1) begin
      errors++;
      $display("FAIL stall_release: got get_coeffs %b layer %0d, required 1 layer 1",
               bus0.get_coeffs, bus0.layer);
    end
    drain(2000, "stall_drain");
    repeat (20) @(negedge clk);

    // Abort in COEF_WAIT together with compute_done.
    sb0.push_back('{K_IMG, 2'd0});
    sb0.push_back('{K_COEF, 2'd0});
    pulse_start();
    wait_sig(K_COEF, 1000, "abort_coef0");
    repeat (5) @(negedge clk);
    bus0.abort = 1'b1; cdone_man = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0; cdone_man = 1'b0;
    check12("abort_idle", pack0(), 12'b0);
    repeat (80) @(negedge clk);
    drain(1, "abort_quiet");

    // Reset during COMP_WAIT, then a fresh frame.
    sb0.push_back('{K_IMG, 2'd0});
    sb0.push_back('{K_COEF, 2'd0});
    sb0.push_back('{K_COMP, 2'd0});
    pulse_start();
    wait_sig(K_COMP, 1000, "rst_comp0");
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check12("rst_async", pack0(), 12'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check12("rst_hold", pack0(), 12'b0);
    end
    drain(1, "rst_pre");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    push_frame();
    pulse_start();
    drain(2000, "rst_frame_drain");
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
